// File: rtl/fe_dispatch_unit_pkg.sv
// pkg_dtypes: shared front-end datatypes used by the dispatch stage
package pkg_dtypes;

    localparam int LOG2_NUM_EXEC_UNITS = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  prd;
    } type_iqueue_entry;

endpackage

// File: rtl/fe_dispatch_unit_lane_alloc.sv
// dispatch_lane_alloc: round-robin EU index per valid lane plus valid-lane count
module dispatch_lane_alloc
    import pkg_dtypes::*;
#(
    parameter int N = 4,
    parameter int M = 2 ** LOG2_NUM_EXEC_UNITS
) (
    input  logic [N-1:0]                          valid_i,
    input  logic [LOG2_NUM_EXEC_UNITS-1:0]        alloc_ptr_i,
    output logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0] euidx_o,
    output logic [$clog2(N+1)-1:0]                count_o
);

    localparam int CW = $clog2(N + 1);

    // each lane's EU is the pointer offset by the number of valid lanes below it
    always_comb begin
        int rank;
        rank = 0;
        for (int k = 0; k < N; k++) begin
            euidx_o[k] = LOG2_NUM_EXEC_UNITS'((int'(alloc_ptr_i) + rank) % M);
            rank += int'(valid_i[k]);
        end
        count_o = CW'(rank);
    end

endmodule

// File: rtl/fe_dispatch_unit.sv
// fe_dispatch_unit: holds a renamed batch and drives it to the EUs until every lane is taken
module fe_dispatch_unit
    import pkg_dtypes::*;
#(
    parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
    parameter int NUM_EXEC_UNITS = 2 ** LOG2_NUM_EXEC_UNITS
) (
    input  logic                                                          clk,
    input  logic                                                          reset_n,
    input  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]          batch_instr_i,
    input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                      batch_valid_i,
    input  logic                                                          batch_req_i,
    output logic                                                          batch_ready_o,
    input  logic                                                          flush_i,
    output type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]          dispatched_instr_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                      dispatched_instr_valid_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][LOG2_NUM_EXEC_UNITS-1:0] dispatched_instr_alloc_euidx_o,
    input  logic [NUM_EXEC_UNITS-1:0]                                     eu_is_full_i,
    output logic [15:0]                                                   stall_cycles_o
);

    localparam int N  = NUM_PARALLEL_INSTR_DISPATCHES;
    localparam int EW = LOG2_NUM_EXEC_UNITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, DISPATCH} state_t;

    state_t                  state, state_next;
    logic [N-1:0]            pending, pending_next, lane_ok, rejected;
    type_iqueue_entry [N-1:0] held;
    logic [N-1:0][EW-1:0]    held_euidx, new_euidx;
    logic [EW-1:0]           alloc_ptr;
    logic [CW-1:0]           count;
    logic                    hs;

    dispatch_lane_alloc #(.N(N), .M(NUM_EXEC_UNITS)) u_alloc (
        .valid_i     (batch_valid_i),
        .alloc_ptr_i (alloc_ptr),
        .euidx_o     (new_euidx),
        .count_o     (count)
    );

    // a lane is taken when the EU it was allocated to is not full this cycle
    always_comb begin
        for (int k = 0; k < N; k++) lane_ok[k] = ~eu_is_full_i[held_euidx[k]];
    end

    assign rejected      = pending & ~lane_ok;
    assign batch_ready_o = ~flush_i & ((state == IDLE) | ((state == DISPATCH) & ~|rejected));
    assign hs            = batch_req_i & batch_ready_o;

    // next state and pending mask; flush dominates, then a new batch, then retirement of taken lanes
    always_comb begin
        state_next   = state;
        pending_next = pending;
        if (flush_i) begin
            state_next   = IDLE;
            pending_next = '0;
        end else if (hs) begin
            pending_next = batch_valid_i;
            state_next   = |batch_valid_i ? DISPATCH : IDLE;
        end else if (state == DISPATCH) begin
            pending_next = rejected;
            state_next   = |rejected ? DISPATCH : IDLE;
        end
    end

    // state, held batch, allocation pointer and stall counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            pending        <= '0;
            held           <= '0;
            held_euidx     <= '0;
            alloc_ptr      <= '0;
            stall_cycles_o <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (hs) begin
                held       <= batch_instr_i;
                held_euidx <= new_euidx;
                alloc_ptr  <= EW'((int'(alloc_ptr) + int'(count)) % NUM_EXEC_UNITS);
            end
            if ((state == DISPATCH) && |rejected && (stall_cycles_o != 16'hFFFF))
                stall_cycles_o <= stall_cycles_o + 16'd1;
        end
    end

    // bus carries only pending lanes of a held batch; everything else is zero
    always_comb begin
        for (int k = 0; k < N; k++) begin
            dispatched_instr_valid_o[k]       = (state == DISPATCH) & pending[k];
            dispatched_instr_o[k]             = dispatched_instr_valid_o[k] ? held[k] : '0;
            dispatched_instr_alloc_euidx_o[k] = dispatched_instr_valid_o[k] ? held_euidx[k] : '0;
        end
    end

endmodule

// File: tb/tb_fe_dispatch_unit.sv
// tb_fe_dispatch_unit: scenario and random checks of fe_dispatch_unit against a batch-level model
module tb_fe_dispatch_unit;
    import pkg_dtypes::*;

    localparam int N = 4;
    localparam int M = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    type_iqueue_entry [N-1:0] batch_instr_i;
    logic [N-1:0] batch_valid_i = '0;
    logic batch_req_i = 1'b0;
    logic batch_ready_o;
    logic flush_i = 1'b0;
    type_iqueue_entry [N-1:0] dispatched_instr_o;
    logic [N-1:0] dispatched_instr_valid_o;
    logic [N-1:0][1:0] dispatched_instr_alloc_euidx_o;
    logic [M-1:0] eu_is_full_i = '0;
    logic [15:0] stall_cycles_o;

    int checks = 0;
    int errors = 0;

    // model: which lanes of the held batch are still owed, their EUs and payload
    bit busy = 0;
    bit [N-1:0] pend = '0;
    int eu[N];
    type_iqueue_entry pay[N];
    int ptr = 0;
    int stalls = 0;

    logic [N-1:0] ev;
    logic [N-1:0][1:0] ee;
    type_iqueue_entry [N-1:0] ep;
    logic er;
    logic [15:0] es;

    always #5 clk = ~clk;

    fe_dispatch_unit #(.NUM_PARALLEL_INSTR_DISPATCHES(N), .NUM_EXEC_UNITS(M)) dut (
        .clk(clk), .reset_n(reset_n),
        .batch_instr_i(batch_instr_i), .batch_valid_i(batch_valid_i),
        .batch_req_i(batch_req_i), .batch_ready_o(batch_ready_o), .flush_i(flush_i),
        .dispatched_instr_o(dispatched_instr_o), .dispatched_instr_valid_o(dispatched_instr_valid_o),
        .dispatched_instr_alloc_euidx_o(dispatched_instr_alloc_euidx_o),
        .eu_is_full_i(eu_is_full_i), .stall_cycles_o(stall_cycles_o)
    );

    function automatic type_iqueue_entry rnd();
        type_iqueue_entry e;
        e.pc = $urandom;
        e.instr = $urandom;
        e.prd = 6'($urandom);
        return e;
    endfunction

    task automatic new_payload();
        for (int k = 0; k < N; k++) batch_instr_i[k] = rnd();
    endtask

    task automatic predict();
        bit ok = 1;
        for (int k = 0; k < N; k++) if (pend[k] && eu_is_full_i[eu[k]]) ok = 0;
        er = !flush_i && (!busy || ok);
        for (int k = 0; k < N; k++) begin
            ev[k] = busy && pend[k];
            ee[k] = ev[k] ? 2'(eu[k]) : 2'd0;
            ep[k] = ev[k] ? pay[k] : '0;
        end
        es = 16'(stalls);
    endtask

    task automatic advance();
        bit rej = 0;
        bit hs;
        int r;
        hs = batch_req_i && er;
        for (int k = 0; k < N; k++) if (busy && pend[k] && eu_is_full_i[eu[k]]) rej = 1;
        @(posedge clk);
        if (!reset_n) begin
            busy = 0; pend = '0; ptr = 0; stalls = 0;
        end else begin
            if (rej && stalls < 65535) stalls++;
            if (flush_i) begin
                pend = '0; busy = 0;
            end else if (hs) begin
                r = 0;
                for (int k = 0; k < N; k++) begin
                    pay[k] = batch_instr_i[k];
                    eu[k] = (ptr + r) % M;
                    if (batch_valid_i[k]) r++;
                end
                ptr = (ptr + r) % M;
                pend = batch_valid_i;
                busy = |batch_valid_i;
            end else if (busy) begin
                for (int k = 0; k < N; k++) if (!eu_is_full_i[eu[k]]) pend[k] = 1'b0;
                busy = |pend;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; batch_req_i = 1; batch_valid_i = '1; flush_i = 0; eu_is_full_i = '0;
        new_payload();
        repeat (2) begin #1; predict(); advance(); end
        #1; predict(); checks += 3;
        if ({dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o} !== '0) begin
            errors++; $display("FAIL reset_bus: got v=%b e=%h want all zero", dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o);
        end
        if (stall_cycles_o !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles_o); end
        if ({dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o} !== {ev, ee, ep}) begin
            errors++; $display("FAIL reset_model: got v=%b want v=%b", dispatched_instr_valid_o, ev);
        end
        advance();
        reset_n = 1; batch_req_i = 0;
        #1; predict(); checks += 1;
        if (batch_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", batch_ready_o); end
        advance();
    endtask

    task automatic test_full_batch();
        for (int c = 0; c < 3; c++) begin
            batch_req_i = (c == 0); batch_valid_i = 4'b1111; eu_is_full_i = '0; new_payload();
            #1; predict(); checks += 3;
            if ({dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o} !== {ev, ee, ep}) begin
                errors++; $display("FAIL full_batch_bus c%0d: got v=%b e=%h p=%h want v=%b e=%h p=%h", c,
                    dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o, ev, ee, ep);
            end
            if ({batch_ready_o, stall_cycles_o} !== {er, es}) begin
                errors++; $display("FAIL full_batch_ctl c%0d: got r=%b s=%0d want r=%b s=%0d", c, batch_ready_o, stall_cycles_o, er, es);
            end
            if (c == 1 && {dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o} !== {4'hF, 2'd3, 2'd2, 2'd1, 2'd0}) begin
                errors++; $display("FAIL full_batch_euidx: got v=%b e=%h want v=1111 e=e4", dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o);
            end else if (c != 1 && batch_ready_o !== 1'b1) begin
                errors++; $display("FAIL full_batch_ready c%0d: got %b want 1", c, batch_ready_o);
            end
            advance();
        end
    endtask

    task automatic test_sparse();
        logic [N-1:0] vals[3] = '{4'b1010, 4'b0111, 4'b0000};
        for (int c = 0; c < 3; c++) begin
            batch_req_i = (c < 2); batch_valid_i = vals[c]; eu_is_full_i = '0; new_payload();
            #1; predict(); checks += 3;
            if ({dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o} !== {ev, ee, ep}) begin
                errors++; $display("FAIL sparse_bus c%0d: got v=%b e=%h want v=%b e=%h", c,
                    dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, ev, ee);
            end
            if ({batch_ready_o, stall_cycles_o} !== {er, es}) begin
                errors++; $display("FAIL sparse_ctl c%0d: got r=%b s=%0d want r=%b s=%0d", c, batch_ready_o, stall_cycles_o, er, es);
            end
            if (c == 1 && (dispatched_instr_alloc_euidx_o[1] !== 2'd0 || dispatched_instr_alloc_euidx_o[3] !== 2'd1)) begin
                errors++; $display("FAIL sparse_first: got lane1=%0d lane3=%0d want 0 1",
                    dispatched_instr_alloc_euidx_o[1], dispatched_instr_alloc_euidx_o[3]);
            end else if (c == 2 && dispatched_instr_alloc_euidx_o[2:0] !== {2'd0, 2'd3, 2'd2}) begin
                errors++; $display("FAIL sparse_second: got lanes2..0=%h want 0e", dispatched_instr_alloc_euidx_o[2:0]);
            end
            advance();
        end
        batch_req_i = 0;
        #1; predict(); advance();
    endtask

    task automatic test_stall();
        reset_n = 0; batch_req_i = 0;
        #1; predict(); advance();
        reset_n = 1;
        for (int c = 0; c < 6; c++) begin
            batch_req_i = (c == 0); batch_valid_i = 4'b1111; new_payload();
            eu_is_full_i = (c >= 1 && c <= 3) ? 4'b0100 : 4'b0000;
            #1; predict(); checks += 3;
            if ({dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o} !== {ev, ee, ep}) begin
                errors++; $display("FAIL stall_bus c%0d: got v=%b e=%h want v=%b e=%h", c,
                    dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, ev, ee);
            end
            if ({batch_ready_o, stall_cycles_o} !== {er, es}) begin
                errors++; $display("FAIL stall_ctl c%0d: got r=%b s=%0d want r=%b s=%0d", c, batch_ready_o, stall_cycles_o, er, es);
            end
            if (c >= 2 && c <= 4 && (dispatched_instr_valid_o !== 4'b0100 || dispatched_instr_alloc_euidx_o[2] !== 2'd2)) begin
                errors++; $display("FAIL stall_retry c%0d: got v=%b e2=%0d want v=0100 e2=2", c,
                    dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o[2]);
            end else if (c == 4 && {batch_ready_o, stall_cycles_o} !== {1'b1, 16'd3}) begin
                errors++; $display("FAIL stall_release: got r=%b s=%0d want r=1 s=3", batch_ready_o, stall_cycles_o);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 5; c++) begin
            batch_req_i = (c == 0 || c == 2 || c == 3);
            batch_valid_i = (c == 3) ? 4'b0001 : 4'($urandom_range(1, 15));
            if (c == 0) batch_valid_i = 4'b1111;
            eu_is_full_i = (c == 1 || c == 2) ? 4'b1111 : 4'b0000;
            flush_i = (c == 2);
            new_payload();
            #1; predict(); checks += 3;
            if ({dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o} !== {ev, ee, ep}) begin
                errors++; $display("FAIL flush_bus c%0d: got v=%b e=%h want v=%b e=%h", c,
                    dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, ev, ee);
            end
            if ({batch_ready_o, stall_cycles_o} !== {er, es}) begin
                errors++; $display("FAIL flush_ctl c%0d: got r=%b s=%0d want r=%b s=%0d", c, batch_ready_o, stall_cycles_o, er, es);
            end
            if (c == 2 && batch_ready_o !== 1'b0) begin
                errors++; $display("FAIL flush_blocks: got ready=%b want 0", batch_ready_o);
            end else if (c == 3 && dispatched_instr_valid_o !== 4'b0000) begin
                errors++; $display("FAIL flush_clear: got v=%b want 0000", dispatched_instr_valid_o);
            end else if (c == 4 && {dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o[0]} !== {4'b0001, 2'd0}) begin
                errors++; $display("FAIL flush_ptr: got v=%b e0=%0d want v=0001 e0=0", dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o[0]);
            end
            advance();
        end
        flush_i = 0;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] prev = '0;
        for (int c = 0; c < 10; c++) begin
            batch_req_i = (c < 9); batch_valid_i = 4'($urandom_range(1, 15)); eu_is_full_i = '0; new_payload();
            #1; predict(); checks += 3;
            if ({dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o} !== {ev, ee, ep}) begin
                errors++; $display("FAIL b2b_bus c%0d: got v=%b e=%h want v=%b e=%h", c,
                    dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, ev, ee);
            end
            if ({batch_ready_o, stall_cycles_o} !== {er, es}) begin
                errors++; $display("FAIL b2b_ctl c%0d: got r=%b s=%0d want r=%b s=%0d", c, batch_ready_o, stall_cycles_o, er, es);
            end
            if ({batch_ready_o, dispatched_instr_valid_o} !== {1'b1, prev}) begin
                errors++; $display("FAIL b2b_nobubble c%0d: got r=%b v=%b want r=1 v=%b", c, batch_ready_o, dispatched_instr_valid_o, prev);
            end
            prev = batch_valid_i;
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            batch_req_i = (c == 0); batch_valid_i = 4'b0001; new_payload();
            eu_is_full_i = (c == 0) ? 4'b0000 : 4'b1111;
            reset_n = !(c == 2 || c == 3);
            #1; predict(); checks += 2;
            if ({dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o} !== {ev, ee, ep}) begin
                errors++; $display("FAIL rstmid_bus c%0d: got v=%b e=%h want v=%b e=%h", c,
                    dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, ev, ee);
            end
            if (c == 3 && {dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o, stall_cycles_o} !== '0) begin
                errors++; $display("FAIL rstmid_zero: got v=%b s=%0d want v=0000 s=0", dispatched_instr_valid_o, stall_cycles_o);
            end else if (c != 3 && {batch_ready_o, stall_cycles_o} !== {er, es}) begin
                errors++; $display("FAIL rstmid_ctl c%0d: got r=%b s=%0d want r=%b s=%0d", c, batch_ready_o, stall_cycles_o, er, es);
            end
            advance();
        end
        reset_n = 1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset_n = ($urandom_range(0, 79) != 0);
            flush_i = ($urandom_range(0, 24) == 0);
            batch_req_i = $urandom_range(0, 1);
            batch_valid_i = 4'($urandom);
            for (int e = 0; e < M; e++) eu_is_full_i[e] = ($urandom_range(0, 3) == 0);
            new_payload();
            #1; predict(); checks += 2;
            if ({dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o} !== {ev, ee, ep}) begin
                errors++; $display("FAIL random_bus c%0d: got v=%b e=%h p=%h want v=%b e=%h p=%h", c,
                    dispatched_instr_valid_o, dispatched_instr_alloc_euidx_o, dispatched_instr_o, ev, ee, ep);
            end
            if ({batch_ready_o, stall_cycles_o} !== {er, es}) begin
                errors++; $display("FAIL random_ctl c%0d: got r=%b s=%0d want r=%b s=%0d", c, batch_ready_o, stall_cycles_o, er, es);
            end
            advance();
        end
    endtask

    initial begin
        new_payload();
        test_reset();
        test_full_batch();
        test_sparse();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fe_dispatch_unit.md
FE_DISPATCH_UNIT -- requirements
Module: fe_dispatch_unit

Interface
REQ-001 SHALL have parameter NUM_PARALLEL_INSTR_DISPATCHES, default 4, giving dispatch bus lanes per batch.
REQ-002 SHALL have parameter NUM_EXEC_UNITS, default 2**LOG2_NUM_EXEC_UNITS, giving the number of EUs on the bus.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 batch_instr_i  input  type_iqueue_entry x N  renamed batch from rename stage.
REQ-006 batch_valid_i  input  1 x N  per-lane valid of the offered batch.
REQ-007 batch_req_i  input  1  batch offered this cycle.
REQ-008 batch_ready_o  output  1  batch accepted when batch_req_i & batch_ready_o.
REQ-009 flush_i  input  1  drop the held batch.
REQ-010 dispatched_instr_o  output  type_iqueue_entry x N  dispatch bus payload.
REQ-011 dispatched_instr_valid_o  output  1 x N  dispatch bus lane valid.
REQ-012 dispatched_instr_alloc_euidx_o  output  LOG2_NUM_EXEC_UNITS x N  target EU per lane.
REQ-013 eu_is_full_i  input  1 x NUM_EXEC_UNITS  per-EU is_full_o; high means that EU rejected all of its lanes this cycle.
REQ-014 stall_cycles_o  output  16  saturating count of cycles with at least one lane rejected.

Function
REQ-015 SHALL implement FSM states IDLE and DISPATCH.
- IDLE -> DISPATCH on a handshake with at least one valid lane.
- DISPATCH -> IDLE when the pending mask clears with no new handshake.
- DISPATCH -> DISPATCH when a new handshake coincides with the clear.
REQ-016 batch_ready_o SHALL be (state==IDLE) | (state==DISPATCH & all pending lanes target EUs with eu_is_full_i low this cycle).
- This is a combinational path from eu_is_full_i.
REQ-017 On handshake, SHALL register instrs, set pending mask = batch_valid_i, and assign euidx per valid lane.
- euidx[k] = (alloc_ptr + rank[k]) mod NUM_EXEC_UNITS.
- rank[k] = number of valid lanes below k.
REQ-018 alloc_ptr (LOG2_NUM_EXEC_UNITS bits) SHALL advance by popcount(batch_valid_i) at handshake, wrapping modulo NUM_EXEC_UNITS.
REQ-019 The euidx assignment SHALL stay fixed for the life of the batch; retries never re-allocate.
REQ-020 In DISPATCH, SHALL drive dispatched_instr_valid_o = pending mask, with held payload and euidx.
- Bus is driven the cycle after the handshake (latency 1).
REQ-021 Each cycle in DISPATCH, SHALL clear the pending bit of every lane whose target EU has eu_is_full_i low.
- Lanes to a full EU stay pending and are re-driven unchanged next cycle.
REQ-022 Non-pending lanes SHALL drive valid 0, payload 0, euidx 0; in IDLE all lanes SHALL drive 0.
REQ-023 A batch with no valid lanes SHALL complete its handshake, leave alloc_ptr unchanged, and not enter DISPATCH.
REQ-024 flush_i SHALL clear the pending mask, force IDLE, block any same-cycle handshake (batch_ready_o low), and preserve alloc_ptr.
REQ-025 stall_cycles_o SHALL increment once per DISPATCH cycle with at least one lane rejected, and saturate at 16'hFFFF.
REQ-026 eu_is_full_i bits for EUs not targeted by a pending lane SHALL be ignored.

Reset
REQ-027 While reset_n is low at posedge, SHALL set state IDLE, pending 0, alloc_ptr 0, stall_cycles_o 0, and all bus outputs 0.
REQ-028 Reset mid-DISPATCH SHALL discard the held batch with no further bus activity.
REQ-029 batch_ready_o SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 type_iqueue_entry and LOG2_NUM_EXEC_UNITS SHALL come from pkg_dtypes; no new package types.
REQ-031 Lane rank/popcount SHALL live in one combinational sub-module, dispatch_lane_alloc (inputs: valid mask, alloc_ptr; outputs: euidx per lane, count).

Verification (N=4, NUM_EXEC_UNITS=4)
REQ-032 Reset, then batch valid=1111 with no full -> bus cycle+1 has euidx 0,1,2,3; ready stays high; alloc_ptr returns to 0.
REQ-033 Batch valid=1010 then batch valid=0111 -> euidx lane1=0, lane3=1; then lanes0..2 = 2,3,0.
REQ-034 Batch 1111, eu_is_full_i[2]=1 for 3 cycles -> lane2 re-driven for 3 cycles with euidx 2, other lanes drop after cycle 1, stall_cycles_o=3, ready high in the cycle full clears.
REQ-035 Held batch with eu_is_full_i=1111 and flush_i pulsed -> bus valid 0 next cycle, state IDLE, next batch 0001 gets euidx 0 (alloc_ptr kept).
REQ-036 Back-to-back batches offered every cycle with no full -> one batch dispatched per cycle, no bubble.
REQ-037 reset_n asserted while lane0 pending -> all outputs 0 next cycle, stall_cycles_o=0.
